mdu_iter: RTL and testbench

Iterative multiply/divide unit providing the RV64M operations that the single-cycle ALU does not cover. It sits beside the ALU in the execute stage and acts as a responder. The execute stage issues one request through a valid/ready handshake. The unit returns one result through a second valid/ready handshake after a multi-cycle shift-add (multiply) or restoring (divide) computation.

---
 rtl/mdu_iter.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_mdu_iter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_iter
//  Purpose  : Iterative RV64M multiply/divide unit. Accepts one request over a
//             valid/ready handshake, runs a shift-add multiply or a restoring
//             divide (one bit per cycle on operand magnitudes), then presents
//             one result over a second valid/ready handshake.
//  Ports    : clk        - rising-edge clock
//             rstn       - asynchronous active-low reset
//             flush      - abort any operation in flight, drop any result
//             req_valid  - request present
//             req_ready  - unit idle and able to accept a request
//             req_op     - operation code (0..12 legal, 13..15 illegal)
//             req_a      - rs1 operand
//             req_b      - rs2 operand
//             resp_valid - result present
//             resp_ready - consumer takes the result
//             resp_res   - result value
//  Options  : MDU_FAST_MUL_EN - when defined, every multiply op finishes
//             through a single-cycle combinational multiplier (IDLE->DONE);
//             divides keep the iterative path. Results are identical.
//  Revision : 1.0 - initial release
// ============================================================================
module mdu_iter #(
   parameter int XLEN = 64  // datapath width; only 64 is supported
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            flush,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [3:0]      req_op,
   input  logic [XLEN-1:0] req_a,
   input  logic [XLEN-1:0] req_b,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_res
);

   localparam logic [3:0] OP_MUL    = 4'd0;
   localparam logic [3:0] OP_MULH   = 4'd1;
   localparam logic [3:0] OP_MULHSU = 4'd2;
   localparam logic [3:0] OP_MULHU  = 4'd3;
   localparam logic [3:0] OP_DIV    = 4'd4;
   localparam logic [3:0] OP_DIVU   = 4'd5;
   localparam logic [3:0] OP_REM    = 4'd6;
   localparam logic [3:0] OP_REMU   = 4'd7;
   localparam logic [3:0] OP_MULW   = 4'd8;
   localparam logic [3:0] OP_DIVW   = 4'd9;
   localparam logic [3:0] OP_DIVUW  = 4'd10;
   localparam logic [3:0] OP_REMW   = 4'd11;
   localparam logic [3:0] OP_REMUW  = 4'd12;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state, state_nx;

   // ------------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------------
   function automatic logic [63:0] sext32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   // Applies the product sign and picks the low, high or W-word result.
   function automatic logic [63:0] mul_sel(input logic w, input logic hi_half,
                                           input logic [127:0] p, input logic neg);
      logic [127:0] s;
      s = neg ? (~p + 128'd1) : p;
      if (w)            return sext32(s[31:0]);
      else if (hi_half) return s[127:64];
      else              return s[63:0];
   endfunction

   // ------------------------------------------------------------------------
   // Request decode (operates directly on the request inputs)
   // ------------------------------------------------------------------------
   logic is_w, is_mul, is_mulh, is_quo, is_rem, a_signed, b_signed, illegal;

   always_comb begin
      is_w     = 1'b0;
      is_mul   = 1'b0;
      is_mulh  = 1'b0;
      is_quo   = 1'b0;
      is_rem   = 1'b0;
      a_signed = 1'b0;
      b_signed = 1'b0;
      illegal  = 1'b0;
      case (req_op)
         OP_MUL:    is_mul = 1'b1;  // low half is sign-independent
         OP_MULH:   begin is_mul = 1'b1; is_mulh = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
         OP_MULHSU: begin is_mul = 1'b1; is_mulh = 1'b1; a_signed = 1'b1; end
         OP_MULHU:  begin is_mul = 1'b1; is_mulh = 1'b1; end
         OP_DIV:    begin is_quo = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
         OP_DIVU:   is_quo = 1'b1;
         OP_REM:    begin is_rem = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
         OP_REMU:   is_rem = 1'b1;
         OP_MULW:   begin is_mul = 1'b1; is_w = 1'b1; end
         OP_DIVW:   begin is_quo = 1'b1; is_w = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
         OP_DIVUW:  begin is_quo = 1'b1; is_w = 1'b1; end
         OP_REMW:   begin is_rem = 1'b1; is_w = 1'b1; a_signed = 1'b1; b_signed = 1'b1; end
         OP_REMUW:  begin is_rem = 1'b1; is_w = 1'b1; end
         default:   illegal = 1'b1;
      endcase
   end

   // Operands widened to 64 bits per op, then reduced to magnitudes.
   logic [63:0] a_ext, b_ext, a_abs, b_abs;
   logic        a_neg, b_neg;

   always_comb begin
      if (is_w) begin
         a_ext = a_signed ? sext32(req_a[31:0]) : {32'd0, req_a[31:0]};
         b_ext = b_signed ? sext32(req_b[31:0]) : {32'd0, req_b[31:0]};
      end else begin
         a_ext = req_a;
         b_ext = req_b;
      end
      a_neg = a_signed & a_ext[63];
      b_neg = b_signed & b_ext[63];
      a_abs = a_neg ? (~a_ext + 64'd1) : a_ext;
      b_abs = b_neg ? (~b_ext + 64'd1) : b_ext;
   end

   // ------------------------------------------------------------------------
   // Special cases resolved at acceptance (no iteration)
   // ------------------------------------------------------------------------
   logic        b_zero, sgn_ovf, fast_hit, special;
   logic [63:0] fast_res, special_res;

   assign b_zero  = is_w ? (req_b[31:0] == 32'd0) : (req_b == 64'd0);
   assign sgn_ovf = a_signed & (is_w ? ((req_a[31:0] == 32'h8000_0000) &&
                                        (req_b[31:0] == 32'hFFFF_FFFF))
                                     : ((req_a == 64'h8000_0000_0000_0000) &&
                                        (req_b == 64'hFFFF_FFFF_FFFF_FFFF)));

`ifdef MDU_FAST_MUL_EN
   logic [127:0] fast_prod;
   assign fast_prod = {64'd0, a_abs} * {64'd0, b_abs};
   assign fast_hit  = is_mul;
   assign fast_res  = mul_sel(is_w, is_mulh, fast_prod, a_neg ^ b_neg);
`else
   assign fast_hit  = 1'b0;
   assign fast_res  = 64'd0;
`endif

   assign special = illegal | fast_hit | ((is_quo | is_rem) & (b_zero | sgn_ovf));

   always_comb begin
      special_res = 64'd0;
      if (illegal) begin
         special_res = 64'd0;
      end else if (fast_hit) begin
         special_res = fast_res;
      end else if (b_zero) begin
         // Divide by zero: quotient all-ones, remainder is the dividend
         // (W dividend always sign-extended from bit 31).
         if (is_quo) special_res = 64'hFFFF_FFFF_FFFF_FFFF;
         else        special_res = is_w ? sext32(req_a[31:0]) : req_a;
      end else if (sgn_ovf) begin
         if (is_quo) special_res = is_w ? 64'hFFFF_FFFF_8000_0000 : req_a;
         else        special_res = 64'd0;
      end
   end

   // ------------------------------------------------------------------------
   // Iteration datapath
   //   Multiply: {hi,lo} starts as {0, multiplier}; each step conditionally
   //   adds the multiplicand to hi and shifts the pair right by one.
   //   Divide:   lo holds the dividend (shifted up 32 for W ops so its MSB
   //   is consumed first); each step shifts {hi,lo} left and restores on a
   //   negative trial subtraction. Quotient lands in lo, remainder in hi.
   // ------------------------------------------------------------------------
   logic [63:0] hi, lo, opd;
   logic [6:0]  cnt;
   logic        op_w, op_mul, op_mulh, op_rem, neg_a, neg_b;

   logic [64:0] mul_sum, div_shift, div_diff;
   logic        div_ok;
   logic [63:0] hi_nx, lo_nx;

   always_comb begin
      mul_sum   = {1'b0, hi} + {1'b0, (lo[0] ? opd : 64'd0)};
      div_shift = {hi, lo[63]};
      div_diff  = div_shift - {1'b0, opd};
      div_ok    = ~div_diff[64];
      if (op_mul) begin
         hi_nx = mul_sum[64:1];
         lo_nx = {mul_sum[0], lo[63:1]};
      end else begin
         hi_nx = div_ok ? div_diff[63:0] : div_shift[63:0];
         lo_nx = {lo[62:0], div_ok};
      end
   end

   // Final result computed from the last iteration's next values.
   logic [127:0] prod_full;
   logic [63:0]  div_val, final_res;

   always_comb begin
      // A 32-step W multiply leaves the product sitting 32 bits high.
      prod_full = op_w ? {32'd0, hi_nx, lo_nx[63:32]} : {hi_nx, lo_nx};
      if (op_rem) div_val = neg_a ? (~hi_nx + 64'd1) : hi_nx;
      else        div_val = (neg_a ^ neg_b) ? (~lo_nx + 64'd1) : lo_nx;
      if (op_mul)    final_res = mul_sel(op_w, op_mulh, prod_full, neg_a ^ neg_b);
      else if (op_w) final_res = sext32(div_val[31:0]);
      else           final_res = div_val;
   end

   // ------------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (flush) begin
         state_nx = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (req_valid) state_nx = special ? S_DONE : S_BUSY;
            S_BUSY:  if (cnt == 7'd1) state_nx = S_DONE;
            S_DONE:  if (resp_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
         endcase
      end
   end

   assign req_ready  = (state == S_IDLE);
   assign resp_valid = (state == S_DONE);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hi       <= 64'd0;
         lo       <= 64'd0;
         opd      <= 64'd0;
         cnt      <= 7'd0;
         op_w     <= 1'b0;
         op_mul   <= 1'b0;
         op_mulh  <= 1'b0;
         op_rem   <= 1'b0;
         neg_a    <= 1'b0;
         neg_b    <= 1'b0;
         resp_res <= 64'd0;
      end else if (flush) begin
         cnt <= 7'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  op_w    <= is_w;
                  op_mul  <= is_mul;
                  op_mulh <= is_mulh;
                  op_rem  <= is_rem;
                  neg_a   <= a_neg;
                  neg_b   <= b_neg;
                  hi      <= 64'd0;
                  lo      <= (!is_mul && is_w) ? {a_abs[31:0], 32'd0} : a_abs;
                  opd     <= b_abs;
                  if (special) begin
                     cnt      <= 7'd0;
                     resp_res <= special_res;
                  end else begin
                     cnt <= is_w ? 7'd32 : 7'd64;
                  end
               end
            end
            S_BUSY: begin
               hi  <= hi_nx;
               lo  <= lo_nx;
               cnt <= cnt - 7'd1;
               if (cnt == 7'd1) resp_res <= final_res;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mdu_iter
//  Purpose  : Self-checking bench for mdu_iter: table of directed operations
//             with hand-computed results and latencies, plus sequences for
//             flush, backpressure and mid-operation reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_iter;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        flush = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_op = 4'd0;
   logic [63:0] req_a = 64'd0;
   logic [63:0] req_b = 64'd0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [63:0] resp_res;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   mdu_iter #(.XLEN(64)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .flush      (flush),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_res   (resp_res)
   );

`ifdef MDU_FAST_MUL_EN
   localparam int ML64 = 1;
   localparam int ML32 = 1;
`else
   localparam int ML64 = 65;
   localparam int ML32 = 33;
`endif
   localparam int DL64 = 65;
   localparam int DL32 = 33;

   typedef struct {
      logic [3:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] res;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Drive one request; returns one sample-phase after the accepting edge.
   task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
      int guard;
      guard = 0;
      while (!req_ready && guard < 300) begin
         @(posedge clk); #1;
         guard++;
      end
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      @(posedge clk); #1;
      req_valid = 1'b0;
      // Operand changes after acceptance must not matter.
      req_a = {$urandom, $urandom};
      req_b = {$urandom, $urandom};
   endtask

   // Latency counts edges from the accepting edge inclusive.
   task automatic wait_resp(output int lat);
      lat = 1;
      while (!resp_valid && lat < 300) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   initial begin
      int lat;
      logic [63:0] held;

      vecs.push_back('{4'd0,  64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, ML64});
      vecs.push_back('{4'd3,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, ML64});
      vecs.push_back('{4'd1,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, ML64});
      vecs.push_back('{4'd2,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, ML64});
      vecs.push_back('{4'd4,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, DL64});
      vecs.push_back('{4'd6,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, DL64});
      vecs.push_back('{4'd5,  64'd100, 64'd7, 64'd14, DL64});
      vecs.push_back('{4'd7,  64'd100, 64'd7, 64'd2, DL64});
      vecs.push_back('{4'd5,  64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1});
      vecs.push_back('{4'd6,  64'd5, 64'd0, 64'd5, 1});
      vecs.push_back('{4'd4,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1});
      vecs.push_back('{4'd10, 64'h8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, DL32});
      vecs.push_back('{4'd8,  64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, ML32});
      vecs.push_back('{4'd12, 64'h1_0000_0007, 64'd3, 64'd1, DL32});
      vecs.push_back('{4'd9,  64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, DL32});
      vecs.push_back('{4'd11, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1});
      vecs.push_back('{4'd12, 64'h8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, 1});
      vecs.push_back('{4'd13, 64'd9, 64'd9, 64'd0, 1});

      // Reset state
      @(posedge clk); #1;
      check("rst_req_ready", {63'd0, req_ready}, 64'd1);
      check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
      check("rst_resp_res", resp_res, 64'd0);
      rstn = 1'b1;
      @(posedge clk); #1;

      // Table of directed operations
      foreach (vecs[i]) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b);
         wait_resp(lat);
         check($sformatf("res[%0d]", i), resp_res, vecs[i].res);
         check($sformatf("lat[%0d]", i), 64'(lat), 64'(vecs[i].lat));
         check($sformatf("done_ready[%0d]", i), {63'd0, req_ready}, 64'd0);
         @(posedge clk); #1;
         check($sformatf("post_ready[%0d]", i), {63'd0, req_ready}, 64'd1);
         check($sformatf("post_valid[%0d]", i), {63'd0, resp_valid}, 64'd0);
      end

      // Flush in BUSY cycle 10: no response ever, idle next cycle
      issue(4'd4, 64'd1000, 64'd3);
      repeat (9) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_ready", {63'd0, req_ready}, 64'd1);
      check("flush_valid", {63'd0, resp_valid}, 64'd0);
      lat = 0;
      repeat (80) begin
         @(posedge clk); #1;
         if (resp_valid) lat++;
      end
      check("flush_no_resp", 64'(lat), 64'd0);
      issue(4'd0, 64'd3, 64'd4);
      wait_resp(lat);
      check("after_flush_res", resp_res, 64'd12);
      check("after_flush_lat", 64'(lat), 64'(ML64));
      @(posedge clk); #1;

      // flush wins over a same-cycle request
      req_valid = 1'b1; req_op = 4'd5; req_a = 64'd9; req_b = 64'd0; flush = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; flush = 1'b0;
      check("flush_req_ready", {63'd0, req_ready}, 64'd1);
      check("flush_req_valid", {63'd0, resp_valid}, 64'd0);

      // Backpressure: result held with resp_ready low for 20 cycles
      resp_ready = 1'b0;
      issue(4'd5, 64'd100, 64'd7);
      wait_resp(lat);
      held = resp_res;
      check("bp_res", held, 64'd14);
      repeat (20) begin
         @(posedge clk); #1;
         check("bp_hold_res", resp_res, 64'd14);
         check("bp_hold_valid", {63'd0, resp_valid}, 64'd1);
         check("bp_hold_ready", {63'd0, req_ready}, 64'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_ready", {63'd0, req_ready}, 64'd1);

      // Reset mid-BUSY: outputs return to reset values without a clock edge
      issue(4'd0, 64'd5, 64'd6);
      repeat (5) begin @(posedge clk); #1; end
      #2 rstn = 1'b0;
      #1;
      check("mid_rst_ready", {63'd0, req_ready}, 64'd1);
      check("mid_rst_valid", {63'd0, resp_valid}, 64'd0);
      check("mid_rst_res", resp_res, 64'd0);
      @(posedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); #1;
      issue(4'd0, 64'd5, 64'd6);
      wait_resp(lat);
      check("post_rst_res", resp_res, 64'd30);
      @(posedge clk); #1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
